// File: rtl/raifes_hasti_arbiter_pkg.sv
// Shared HASTI widths, HTRANS encodings and arbiter master indices for the
// single-port SRAM arbiter.
package raifes_hasti_arbiter_pkg;

  localparam int HASTI_ADDR_WIDTH  = 32;
  localparam int HASTI_BUS_WIDTH   = 32;
  localparam int HASTI_SIZE_WIDTH  = 3;
  localparam int HASTI_BURST_WIDTH = 3;
  localparam int HASTI_PROT_WIDTH  = 4;
  localparam int HASTI_TRANS_WIDTH = 2;

  typedef enum logic [HASTI_TRANS_WIDTH-1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

  function automatic logic is_request(input logic [HASTI_TRANS_WIDTH-1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/raifes_hasti_arb_hold.sv
// Per-master response hold register plus the hready/hrdata/hresp return mux
// that hides arbitration stalls from one master.
module raifes_hasti_arb_hold
  import raifes_hasti_arbiter_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       req,
  input  logic                       gnt,
  input  logic                       owner,
  input  logic                       s_hready,
  input  logic [HASTI_BUS_WIDTH-1:0] s_hrdata,
  input  logic                       s_hresp,
  output logic                       hold_valid,
  output logic                       hready,
  output logic [HASTI_BUS_WIDTH-1:0] hrdata,
  output logic                       hresp
);

  logic [HASTI_BUS_WIDTH-1:0] hold_rdata;
  logic                       hold_resp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_valid <= 1'b0;
      hold_rdata <= '0;
      hold_resp  <= 1'b0;
    end else if (s_hready) begin
      // Our data phase ends while our next address loses: park the response.
      if (owner && req && !gnt) begin
        hold_valid <= 1'b1;
        hold_rdata <= s_hrdata;
        hold_resp  <= s_hresp;
      end else if (hold_valid && gnt) begin
        hold_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    hrdata = '0;
    hresp  = 1'b0;
    if (hold_valid) begin
      hready = gnt & s_hready;
      hrdata = hold_rdata;
      hresp  = hold_resp;
    end else if (owner) begin
      hready = s_hready & (gnt | !req);
      hrdata = s_hrdata;
      hresp  = s_hresp;
    end else if (req) begin
      // A waiting address is only accepted when the grant actually lands.
      hready = gnt & s_hready;
    end else begin
      hready = 1'b1;
    end
  end

endmodule

// File: rtl/raifes_hasti_arbiter.sv
// Two-master (imem m0, dmem m1) arbiter in front of one single-port HASTI SRAM.
// Define RAIFES_ARB_RR_EN for round-robin tie-break instead of PRIO_DMEM.
module raifes_hasti_arbiter
  import raifes_hasti_arbiter_pkg::*;
#(
  parameter bit PRIO_DMEM = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [HASTI_ADDR_WIDTH-1:0]  m0_haddr,
  input  logic                         m0_hwrite,
  input  logic [HASTI_SIZE_WIDTH-1:0]  m0_hsize,
  input  logic [HASTI_BURST_WIDTH-1:0] m0_hburst,
  input  logic                         m0_hmastlock,
  input  logic [HASTI_PROT_WIDTH-1:0]  m0_hprot,
  input  logic [HASTI_TRANS_WIDTH-1:0] m0_htrans,
  input  logic [HASTI_BUS_WIDTH-1:0]   m0_hwdata,
  output logic [HASTI_BUS_WIDTH-1:0]   m0_hrdata,
  output logic                         m0_hready,
  output logic                         m0_hresp,
  input  logic [HASTI_ADDR_WIDTH-1:0]  m1_haddr,
  input  logic                         m1_hwrite,
  input  logic [HASTI_SIZE_WIDTH-1:0]  m1_hsize,
  input  logic [HASTI_BURST_WIDTH-1:0] m1_hburst,
  input  logic                         m1_hmastlock,
  input  logic [HASTI_PROT_WIDTH-1:0]  m1_hprot,
  input  logic [HASTI_TRANS_WIDTH-1:0] m1_htrans,
  input  logic [HASTI_BUS_WIDTH-1:0]   m1_hwdata,
  output logic [HASTI_BUS_WIDTH-1:0]   m1_hrdata,
  output logic                         m1_hready,
  output logic                         m1_hresp,
  output logic [HASTI_ADDR_WIDTH-1:0]  s_haddr,
  output logic                         s_hwrite,
  output logic [HASTI_SIZE_WIDTH-1:0]  s_hsize,
  output logic [HASTI_BURST_WIDTH-1:0] s_hburst,
  output logic                         s_hmastlock,
  output logic [HASTI_PROT_WIDTH-1:0]  s_hprot,
  output logic [HASTI_TRANS_WIDTH-1:0] s_htrans,
  output logic [HASTI_BUS_WIDTH-1:0]   s_hwdata,
  input  logic [HASTI_BUS_WIDTH-1:0]   s_hrdata,
  input  logic                         s_hready,
  input  logic                         s_hresp,
  output logic [1:0]                   arb_owner
);

  logic req0, req1, gnt0, gnt1, any_gnt;
  logic dp_valid, dp_owner, last_lock;
  logic hold0_valid, hold1_valid;
  logic own0, own1, lock_active, tie_m1;

  // Requests are masked in reset so the slave sees IDLE immediately.
  assign req0 = reset_n & is_request(m0_htrans);
  assign req1 = reset_n & is_request(m1_htrans);

  assign lock_active = last_lock & ((dp_owner == ARB_M1) ? m1_hmastlock : m0_hmastlock);

`ifdef RAIFES_ARB_RR_EN
  logic last_gnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      last_gnt <= ARB_M0;
    else if (s_hready && any_gnt)
      last_gnt <= gnt1;
  end

  assign tie_m1 = (last_gnt == ARB_M0);
`else
  assign tie_m1 = PRIO_DMEM;
`endif

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (lock_active) begin
      if (dp_owner == ARB_M1) gnt1 = req1;
      else                    gnt0 = req0;
    end else if (req0 && req1) begin
      // A parked response outranks a fresh request so the loser cannot starve.
      if (hold0_valid && !hold1_valid)      gnt0 = 1'b1;
      else if (hold1_valid && !hold0_valid) gnt1 = 1'b1;
      else if (tie_m1)                      gnt1 = 1'b1;
      else                                  gnt0 = 1'b1;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

  assign any_gnt = gnt0 | gnt1;

  assign s_haddr     = gnt1 ? m1_haddr     : m0_haddr;
  assign s_hwrite    = gnt1 ? m1_hwrite    : m0_hwrite;
  assign s_hsize     = gnt1 ? m1_hsize     : m0_hsize;
  assign s_hburst    = gnt1 ? m1_hburst    : m0_hburst;
  assign s_hmastlock = gnt1 ? m1_hmastlock : m0_hmastlock;
  assign s_hprot     = gnt1 ? m1_hprot     : m0_hprot;
  assign s_htrans    = gnt1 ? m1_htrans : (gnt0 ? m0_htrans : HTRANS_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dp_valid  <= 1'b0;
      dp_owner  <= ARB_M0;
      last_lock <= 1'b0;
    end else if (s_hready) begin
      dp_valid  <= any_gnt;
      dp_owner  <= gnt1;
      last_lock <= gnt1 ? m1_hmastlock : (gnt0 & m0_hmastlock);
    end
  end

  assign s_hwdata  = (dp_owner == ARB_M1) ? m1_hwdata : m0_hwdata;
  assign own0      = dp_valid & (dp_owner == ARB_M0);
  assign own1      = dp_valid & (dp_owner == ARB_M1);
  assign arb_owner = {dp_valid, dp_owner};

  raifes_hasti_arb_hold u_hold0 (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req0),
    .gnt        (gnt0),
    .owner      (own0),
    .s_hready   (s_hready),
    .s_hrdata   (s_hrdata),
    .s_hresp    (s_hresp),
    .hold_valid (hold0_valid),
    .hready     (m0_hready),
    .hrdata     (m0_hrdata),
    .hresp      (m0_hresp)
  );

  raifes_hasti_arb_hold u_hold1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req1),
    .gnt        (gnt1),
    .owner      (own1),
    .s_hready   (s_hready),
    .s_hrdata   (s_hrdata),
    .s_hresp    (s_hresp),
    .hold_valid (hold1_valid),
    .hready     (m1_hready),
    .hrdata     (m1_hrdata),
    .hresp      (m1_hresp)
  );

endmodule

// File: tb/tb_raifes_hasti_arbiter.sv
// Bench for raifes_hasti_arbiter: SRAM model, per-master read scoreboards and
// directed contention, lock, error, round-robin and reset scenarios.
module tb_raifes_hasti_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] m0_haddr, m0_hwdata, m0_hrdata;
  logic        m0_hwrite, m0_hmastlock, m0_hready, m0_hresp;
  logic [2:0]  m0_hsize, m0_hburst;
  logic [3:0]  m0_hprot;
  logic [1:0]  m0_htrans;
  logic [31:0] m1_haddr, m1_hwdata, m1_hrdata;
  logic        m1_hwrite, m1_hmastlock, m1_hready, m1_hresp;
  logic [2:0]  m1_hsize, m1_hburst;
  logic [3:0]  m1_hprot;
  logic [1:0]  m1_htrans;
  logic [31:0] s_haddr, s_hwdata, s_hrdata;
  logic        s_hwrite, s_hmastlock, s_hready, s_hresp;
  logic [2:0]  s_hsize, s_hburst;
  logic [3:0]  s_hprot;
  logic [1:0]  s_htrans;
  logic [1:0]  arb_owner;

  always #5 clk = ~clk;

  raifes_hasti_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_haddr(m0_haddr), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize), .m0_hburst(m0_hburst),
    .m0_hmastlock(m0_hmastlock), .m0_hprot(m0_hprot), .m0_htrans(m0_htrans), .m0_hwdata(m0_hwdata),
    .m0_hrdata(m0_hrdata), .m0_hready(m0_hready), .m0_hresp(m0_hresp),
    .m1_haddr(m1_haddr), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize), .m1_hburst(m1_hburst),
    .m1_hmastlock(m1_hmastlock), .m1_hprot(m1_hprot), .m1_htrans(m1_htrans), .m1_hwdata(m1_hwdata),
    .m1_hrdata(m1_hrdata), .m1_hready(m1_hready), .m1_hresp(m1_hresp),
    .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hsize(s_hsize), .s_hburst(s_hburst),
    .s_hmastlock(s_hmastlock), .s_hprot(s_hprot), .s_htrans(s_htrans), .s_hwdata(s_hwdata),
    .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp),
    .arb_owner(arb_owner)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'hCAFE_F00D;
      32'h0000_0200: return 32'h1122_3344;
      default:       return {a[15:0], ~a[15:0]};
    endcase
  endfunction

  // SRAM slave model: zero-wait unless the stimulus pulls s_hready low.
  logic        sl_dp, sl_wr;
  logic [31:0] sl_addr;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sl_dp   <= 1'b0;
      sl_wr   <= 1'b0;
      sl_addr <= '0;
    end else if (s_hready) begin
      sl_dp   <= s_htrans[1];
      sl_wr   <= s_hwrite;
      sl_addr <= s_haddr;
    end
  end

  assign s_hrdata = (sl_dp && !sl_wr) ? mem_val(sl_addr) : 32'hBAD0_0BAD;

  // Master-side tracking: expected read data queued at address acceptance.
  logic        m0_dp = 1'b0, m0_dp_wr = 1'b0, m1_dp = 1'b0, m1_dp_wr = 1'b0;
  logic [31:0] m0_dp_addr = '0, m1_dp_addr = '0;
  logic [31:0] rd_q0[$];
  logic [31:0] rd_q1[$];

  assign m0_hwdata = ~m0_dp_addr;
  assign m1_hwdata = ~m1_dp_addr;

  always @(negedge clk) begin
    if (!reset_n) begin
      m0_dp = 1'b0;
      m1_dp = 1'b0;
      rd_q0.delete();
      rd_q1.delete();
    end else begin
      if (sl_dp && sl_wr && s_hready)
        check("s_hwdata", s_hwdata, ~sl_addr);
      if (m0_dp && m0_hready && !m0_dp_wr) begin
        check("m0_rd_q_nonempty", 32'(rd_q0.size() != 0), 32'd1);
        if (rd_q0.size() != 0) check("m0_hrdata_sb", m0_hrdata, rd_q0.pop_front());
      end
      if (m1_dp && m1_hready && !m1_dp_wr) begin
        check("m1_rd_q_nonempty", 32'(rd_q1.size() != 0), 32'd1);
        if (rd_q1.size() != 0) check("m1_hrdata_sb", m1_hrdata, rd_q1.pop_front());
      end
      if (m0_hready) begin
        m0_dp = m0_htrans[1]; m0_dp_wr = m0_hwrite; m0_dp_addr = m0_haddr;
        if (m0_htrans[1] && !m0_hwrite) rd_q0.push_back(mem_val(m0_haddr));
      end
      if (m1_hready) begin
        m1_dp = m1_htrans[1]; m1_dp_wr = m1_hwrite; m1_dp_addr = m1_haddr;
        if (m1_htrans[1] && !m1_hwrite) rd_q1.push_back(mem_val(m1_haddr));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int m, input logic [1:0] tr, input logic [31:0] a,
                     input logic wr, input logic lk);
    if (m == 0) begin
      m0_htrans = tr; m0_haddr = a; m0_hwrite = wr; m0_hmastlock = lk;
    end else begin
      m1_htrans = tr; m1_haddr = a; m1_hwrite = wr; m1_hmastlock = lk;
    end
  endtask

  task automatic reset_checks(input string pfx);
    check({pfx, "_s_htrans"}, 32'(s_htrans), 32'd0);
    check({pfx, "_arb_owner"}, 32'(arb_owner), 32'd0);
    check({pfx, "_m0_hready"}, 32'(m0_hready), 32'd1);
    check({pfx, "_m1_hready"}, 32'(m1_hready), 32'd1);
    check({pfx, "_m0_hrdata"}, m0_hrdata, 32'd0);
    check({pfx, "_m1_hrdata"}, m1_hrdata, 32'd0);
    check({pfx, "_m0_hresp"}, 32'(m0_hresp), 32'd0);
    check({pfx, "_m1_hresp"}, 32'(m1_hresp), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] a0, a1;
  logic        exp_m1, acc0, acc1;

  initial begin
    reset_n = 1'b0;
    s_hready = 1'b1;
    s_hresp = 1'b0;
    m0_hsize = 3'b010; m0_hburst = 3'b000; m0_hprot = 4'b0011;
    m1_hsize = 3'b010; m1_hburst = 3'b000; m1_hprot = 4'b0011;
    drv(0, 2'b00, 32'h0, 1'b0, 1'b0);
    drv(1, 2'b00, 32'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_checks("rst");
    tick();
    reset_n = 1'b1;

    // Uncontested imem read of 0x100
    tick(); drv(0, 2'b10, 32'h100, 1'b0, 1'b0);
    @(negedge clk);
    check("t1_m0_hready_a", 32'(m0_hready), 32'd1);
    check("t1_s_haddr", s_haddr, 32'h100);
    check("t1_s_htrans", 32'(s_htrans), 32'd2);
    check("t1_m1_hready", 32'(m1_hready), 32'd1);
    tick(); drv(0, 2'b00, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("t1_m0_hready_d", 32'(m0_hready), 32'd1);
    check("t1_m0_hrdata", m0_hrdata, 32'hCAFE_F00D);
    check("t1_arb_owner", 32'(arb_owner), 32'd2);

    // Simultaneous NONSEQ: dmem wins, imem follows next cycle
    tick(); drv(0, 2'b10, 32'h300, 1'b0, 1'b0); drv(1, 2'b10, 32'h400, 1'b0, 1'b0);
    @(negedge clk);
    check("t2_s_haddr_first", s_haddr, 32'h400);
    check("t2_m0_hready_stall", 32'(m0_hready), 32'd0);
    check("t2_m1_hready", 32'(m1_hready), 32'd1);
    tick(); drv(1, 2'b00, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("t2_s_haddr_second", s_haddr, 32'h300);
    check("t2_m0_hready_go", 32'(m0_hready), 32'd1);
    tick(); drv(0, 2'b00, 32'h0, 1'b0, 1'b0);

    // imem data phase captured by hold register while dmem wins
    tick(); drv(0, 2'b10, 32'h200, 1'b0, 1'b0);
    @(negedge clk);
    check("t3_s_haddr_200", s_haddr, 32'h200);
    tick(); drv(0, 2'b10, 32'h204, 1'b0, 1'b0); drv(1, 2'b10, 32'h500, 1'b0, 1'b0);
    @(negedge clk);
    check("t3_s_haddr_m1", s_haddr, 32'h500);
    check("t3_m0_hready_hold", 32'(m0_hready), 32'd0);
    tick(); drv(1, 2'b10, 32'h504, 1'b0, 1'b0);
    @(negedge clk);
    check("t3_s_haddr_hold_prio", s_haddr, 32'h204);
    check("t3_m0_hready_rel", 32'(m0_hready), 32'd1);
    check("t3_m0_hrdata_hold", m0_hrdata, 32'h1122_3344);
    check("t3_m1_hready_hold", 32'(m1_hready), 32'd0);
    tick(); drv(0, 2'b00, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("t3_s_haddr_m1_held", s_haddr, 32'h504);
    check("t3_m1_hready_rel", 32'(m1_hready), 32'd1);
    check("t3_m1_hrdata_hold", m1_hrdata, mem_val(32'h500));
    tick(); drv(1, 2'b00, 32'h0, 1'b0, 1'b0);

    // Locked dmem write pair keeps imem out despite its parked response
    tick(); drv(0, 2'b10, 32'h6F0, 1'b0, 1'b0);
    tick(); drv(0, 2'b10, 32'h700, 1'b0, 1'b0); drv(1, 2'b10, 32'h600, 1'b1, 1'b1);
    @(negedge clk);
    check("t4_s_haddr_w0", s_haddr, 32'h600);
    check("t4_s_hwrite", 32'(s_hwrite), 32'd1);
    check("t4_m0_hready_w0", 32'(m0_hready), 32'd0);
    tick(); drv(1, 2'b10, 32'h604, 1'b1, 1'b1);
    @(negedge clk);
    check("t4_s_haddr_w1", s_haddr, 32'h604);
    check("t4_m0_hready_w1", 32'(m0_hready), 32'd0);
    check("t4_m1_hready_w1", 32'(m1_hready), 32'd1);
    tick(); drv(1, 2'b00, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("t4_s_haddr_unlock", s_haddr, 32'h700);
    check("t4_m0_hready_unlock", 32'(m0_hready), 32'd1);
    check("t4_m0_hrdata_hold", m0_hrdata, mem_val(32'h6F0));
    tick(); drv(0, 2'b00, 32'h0, 1'b0, 1'b0);

    // Two-cycle ERROR on a dmem write
    tick(); drv(1, 2'b10, 32'h800, 1'b1, 1'b0);
    @(negedge clk);
    check("t5_s_haddr", s_haddr, 32'h800);
    tick(); drv(1, 2'b00, 32'h0, 1'b0, 1'b0); s_hready = 1'b0; s_hresp = 1'b1;
    @(negedge clk);
    check("t5_err1_hready", 32'(m1_hready), 32'd0);
    check("t5_err1_hresp", 32'(m1_hresp), 32'd1);
    check("t5_err1_owner", 32'(arb_owner), 32'd3);
    tick(); s_hready = 1'b1;
    @(negedge clk);
    check("t5_err2_owner", 32'(arb_owner), 32'd3);
    check("t5_err2_hready", 32'(m1_hready), 32'd1);
    check("t5_err2_hresp", 32'(m1_hresp), 32'd1);
    tick(); s_hresp = 1'b0;
    @(negedge clk);
    check("t5_after_owner", 32'(arb_owner), 32'd0);
    check("t5_after_hresp", 32'(m1_hresp), 32'd0);

    // Continuous contention from a fresh reset, then reset mid-burst
    tick(); reset_n = 1'b0;
    tick(); reset_n = 1'b1;
    a0 = 32'h1000; a1 = 32'h2000;
    tick(); drv(0, 2'b10, a0, 1'b0, 1'b0); drv(1, 2'b10, a1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
`ifdef RAIFES_ARB_RR_EN
      exp_m1 = (i % 2 == 0);
`else
      exp_m1 = 1'b1;
`endif
      check($sformatf("t6_s_haddr_%0d", i), s_haddr, exp_m1 ? a1 : a0);
      check($sformatf("t6_win_rdy_%0d", i), 32'(exp_m1 ? m1_hready : m0_hready), 32'd1);
      check($sformatf("t6_lose_rdy_%0d", i), 32'(exp_m1 ? m0_hready : m1_hready), 32'd0);
      acc0 = m0_hready;
      acc1 = m1_hready;
      tick();
      if (acc0) a0 = a0 + 32'd4;
      if (acc1) a1 = a1 + 32'd4;
      drv(0, 2'b10, a0, 1'b0, 1'b0);
      drv(1, 2'b10, a1, 1'b0, 1'b0);
    end
    #2 reset_n = 1'b0;
    #1 reset_checks("midrst");
    drv(0, 2'b00, 32'h0, 1'b0, 1'b0);
    drv(1, 2'b00, 32'h0, 1'b0, 1'b0);
    tick(); tick(); reset_n = 1'b1;

    // Uncontested dmem read after reset
    tick(); drv(1, 2'b10, 32'h340, 1'b0, 1'b0);
    @(negedge clk);
    check("t7_s_haddr", s_haddr, 32'h340);
    tick(); drv(1, 2'b00, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("t7_m1_hrdata", m1_hrdata, mem_val(32'h340));
    check("t7_arb_owner", 32'(arb_owner), 32'd3);
    tick(); tick();
    @(negedge clk);
    check("rd_q0_drained", 32'(rd_q0.size()), 32'd0);
    check("rd_q1_drained", 32'(rd_q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
